// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared constants for the bit-serial arithmetic blocks
//
// Holds the FSM state encoding used by serial_subtractor and the default
// operand width for the serial datapath library.

package serial_arith_pkg;

  // Default operand/result width for the serial arithmetic blocks.
  localparam int DEFAULT_WIDTH = 8;

  // Sequencer states shared by the serial arithmetic blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - combinational one-bit full-subtractor slice
//
// Computes a - b - bin for single bits.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in from the less significant bit
//   d    out difference bit
//   bout out borrow out to the more significant bit

module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow
  // arrives from below.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, diff = a - b over WIDTH cycles, LSB first
//
// One full-subtractor slice plus a registered borrow, sequenced by an
// IDLE/RUN/DONE FSM with a start/done handshake.
// Optional build macro: SERIAL_SUB_OVERFLOW_EN adds the signed overflow output.
// Ports:
//   clk         in  rising-edge clock
//   rst_n       in  asynchronous active-low reset
//   start       in  request, sampled only in IDLE
//   a           in  [WIDTH] minuend, captured on the start-sampling edge
//   b           in  [WIDTH] subtrahend, captured on the start-sampling edge
//   busy        out high while in RUN
//   done        out one-cycle pulse when diff/borrow_out are updated
//   diff        out [WIDTH] registered a - b mod 2^WIDTH
//   borrow_out  out final borrow (a < b unsigned)
//   overflow    out signed overflow (only with SERIAL_SUB_OVERFLOW_EN)

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // One extra bit so that WIDTH=1 still gets a legal, non-zero-width counter.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               slice_d;
  logic               slice_bout;
  logic [WIDTH-1:0]   sr_shift;
  logic               last_bit;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               sa_msb_q, sa_msb_d;
  logic               sb_msb_q, sb_msb_d;
  logic               ov_q, ov_d;
`endif

  full_subtractor_bit u_slice (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // New difference bit enters at the MSB; written as shift/or so it stays
  // legal for WIDTH=1, where there are no lower bits to keep.
  assign sr_shift = (sr_q >> 1) | (WIDTH'(slice_d) << (WIDTH - 1));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    sa_msb_d = sa_msb_q;
    sb_msb_d = sb_msb_q;
    ov_d     = ov_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          sa_msb_d = a[WIDTH-1];
          sb_msb_d = b[WIDTH-1];
`endif
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        br_d  = slice_bout;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Publish the completed result on the same edge as the final bit.
          diff_d   = sr_shift;
          borrow_d = slice_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // Operands of differing sign whose result sign disagrees with the
          // minuend have left the signed range.
          ov_d = (sa_msb_q ^ sb_msb_q) & (sr_shift[WIDTH-1] ^ sa_msb_q);
`endif
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered decodes of the next state, so they line
    // up exactly with the state they describe and have no input path.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      sa_msb_q <= 1'b0;
      sb_msb_q <= 1'b0;
      ov_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      sa_msb_q <= sa_msb_d;
      sb_msb_q <= sb_msb_d;
      ov_q     <= ov_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow   = ov_q;
`endif

endmodule
